// File: rtl/booth_divider_seq.sv
// booth_divider_seq
//   Iterative unsigned divider: a 2*DW-bit dividend divided by a DW-bit
//   divisor, producing a DW-bit quotient and a DW-bit remainder. It undoes
//   the registered DW x DW Booth multiplier: feeding it a product and one
//   operand recovers the other operand. It uses radix-2 restoring division
//   and resolves one quotient bit per clock.
//
//   Operation is a three-state sequence: IDLE -> CALC -> DONE.
//   - The accept edge only latches the operands.
//   - The first CALC cycle classifies the operation from the registered
//     operands, which keeps the compare off the input path:
//     - Divide-by-zero and quotient overflow go straight to DONE.
//     - A normal division seeds the partial remainder and the quotient
//       shift register.
//   - DW trial-subtract iterations follow. The result reaches the output
//     registers on the last iteration edge.
//   - Normal results: out_valid rises after edge DW+1 (the accept edge is
//     edge 0).
//   - Special cases: out_valid rises after edge 1.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   in_valid     in   operand valid
//   in_ready     out  ready for a new operation (IDLE only)
//   dividend     in   [2*DW-1:0] unsigned dividend
//   divisor      in   [DW-1:0]   unsigned divisor
//   out_valid    out  result valid (DONE)
//   out_ready    in   consumer takes the result
//   quotient     out  [DW-1:0] unsigned quotient
//   remainder    out  [DW-1:0] unsigned remainder
//   div_by_zero  out  divisor was zero
//   overflow     out  quotient does not fit in DW bits
module booth_divider_seq #(
  parameter int DW = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic            setup;     // first CALC cycle: classify and seed
  logic [CW-1:0]   cnt;
  logic [2*DW-1:0] dvd;
  logic [DW-1:0]   dvs;
  logic [DW:0]     prem;      // partial remainder
  logic [DW-1:0]   qsr;       // dividend low bits shift out, quotient bits shift in

  // One restoring step: shift {prem, qsr} left, then trial-subtract.
  // The extra top bit of diff is the borrow, so ge means "keep the
  // difference".
  logic [DW+1:0] shifted;
  logic [DW+1:0] diff;
  logic          ge;
  logic [DW:0]   next_prem;
  logic [DW-1:0] next_q;

  always_comb begin
    shifted   = {prem, qsr[DW-1]};
    diff      = shifted - {2'b00, dvs};
    ge        = ~diff[DW+1];
    next_prem = ge ? diff[DW:0] : shifted[DW:0];
    next_q    = {qsr[DW-2:0], ge};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      setup       <= 1'b0;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      qsr         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd   <= dividend;
            dvs   <= divisor;
            setup <= 1'b1;
            state <= CALC;
          end
        end

        CALC: begin
          if (setup) begin
            setup <= 1'b0;
            if (dvs == '0) begin
              quotient    <= '1;
              remainder   <= dvd[DW-1:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              state       <= DONE;
            end else if (dvd[2*DW-1:DW] >= dvs) begin
              // Upper half >= divisor means the quotient needs more than DW bits.
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              state       <= DONE;
            end else begin
              cnt  <= '0;
              prem <= {1'b0, dvd[2*DW-1:DW]};
              qsr  <= dvd[DW-1:0];
            end
          end else begin
            prem <= next_prem;
            qsr  <= next_q;
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(DW - 1)) begin
              quotient    <= next_q;
              remainder   <= next_prem[DW-1:0];
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
              state       <= DONE;
            end
          end
        end

        DONE: begin
          if (out_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider_seq.sv
// Testbench for booth_divider_seq. It uses directed and randomized
// operations and compares against a plain-arithmetic reference model.
module tb_booth_divider_seq;

  localparam int DW = 24;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2*DW-1:0] dividend = '0;
  logic [DW-1:0]   divisor = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   quotient;
  logic [DW-1:0]   remainder;
  logic            div_by_zero;
  logic            overflow;

  int n_vec = 0;
  int n_err = 0;

  booth_divider_seq #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the results follow directly from the division rules.
  task automatic model(input logic [47:0] a, input logic [23:0] b,
                       output logic [23:0] q, output logic [23:0] r,
                       output logic dz, output logic ov, output int lat);
    logic [47:0] qq, rr;
    dz = 1'b0; ov = 1'b0;
    if (b == 24'd0) begin
      dz = 1'b1; q = 24'hFFFFFF; r = a[23:0]; lat = 1;
    end else if ((a / {24'd0, b}) > 48'hFFFFFF) begin
      ov = 1'b1; q = 24'hFFFFFF; r = 24'd0; lat = 1;
    end else begin
      qq = a / {24'd0, b};
      rr = a % {24'd0, b};
      q = qq[23:0]; r = rr[23:0]; lat = DW + 1;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one operation. A nonzero hold keeps out_ready low for that many
  // cycles after the result appears, while the inputs are scrambled.
  task automatic do_op(input logic [47:0] a, input logic [23:0] b, input int hold);
    logic [23:0] eq, er;
    logic edz, eov;
    int elat, lat;
    bit seen;
    model(a, b, eq, er, edz, eov, elat);
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    check("in_ready_idle", 64'(in_ready), 64'(1));
    out_ready = (hold == 0);
    in_valid = 1'b1; dividend = a; divisor = b;
    tick();
    in_valid = 1'b0;
    dividend = {$urandom, $urandom} ; divisor = 24'($urandom);
    check("in_ready_busy", 64'(in_ready), 64'(0));
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      if (out_valid) seen = 1'b1;
      else begin tick(); lat++; end
    end
    check("latency", 64'(lat), 64'(elat));
    check("quotient", 64'(quotient), 64'(eq));
    check("remainder", 64'(remainder), 64'(er));
    check("div_by_zero", 64'(div_by_zero), 64'(edz));
    check("overflow", 64'(overflow), 64'(eov));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'($urandom);
        dividend = {$urandom, $urandom};
        divisor = 24'($urandom);
        tick();
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_in_ready", 64'(in_ready), 64'(0));
        check("hold_quotient", 64'(quotient), 64'(eq));
        check("hold_remainder", 64'(remainder), 64'(er));
        check("hold_flags", 64'({div_by_zero, overflow}), 64'({edz, eov}));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    check("handoff_valid", 64'(out_valid), 64'(0));
    check("handoff_in_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [23:0] b, q, hi;
    logic [47:0] a;
    int mode;

    // Reset state
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_quotient", 64'(quotient), 64'(0));
    check("rst_remainder", 64'(remainder), 64'(0));
    check("rst_flags", 64'({div_by_zero, overflow}), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed cases
    do_op(48'd100, 24'd7, 0);
    do_op(48'hFFFFFE000001, 24'hFFFFFF, 0);
    do_op(48'h000000123456, 24'd0, 0);
    do_op(48'h000001000000, 24'd1, 0);
    do_op(48'h000000FFFFFF, 24'd1, 0);
    do_op(48'd0, 24'd5, 0);

    // Backpressure, then a second division
    do_op(48'd987654321, 24'd1234, 10);
    do_op(48'd555555, 24'd77, 0);

    // Reset during iteration 10
    in_valid = 1'b1; dividend = 48'd123456789; divisor = 24'd4321;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_quotient", 64'(quotient), 64'(0));
    check("midrst_remainder", 64'(remainder), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_no_result", 64'(out_valid), 64'(0));
    do_op(48'd1000, 24'd3, 0);

    // Randomized operations
    for (int n = 0; n < 150; n++) begin
      mode = int'($urandom_range(0, 9));
      b = 24'($urandom_range(1, 24'hFFFFFF));
      if (mode == 0) begin
        a = {$urandom, $urandom};
        b = 24'd0;
      end else if (mode == 1) begin
        hi = 24'($urandom_range(int'(b), 24'hFFFFFF));
        a = {hi, 24'($urandom)};
      end else begin
        if (mode == 2) b = 24'($urandom_range(1, 15));
        q = 24'($urandom);
        a = {24'd0, q} * {24'd0, b} + 48'($urandom % {8'd0, b});
      end
      do_op(a, b, (mode == 3) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
